// File: rtl/jtframe_joy_pkg.sv
// Shared joystick definitions: direction bit indices, 4-way priority order
// and the small combinational helpers used by the 4-way filter.
package jtframe_joy_pkg;

    localparam int DIR_RIGHT = 0;
    localparam int DIR_LEFT  = 1;
    localparam int DIR_DOWN  = 2;
    localparam int DIR_UP    = 3;
    localparam int NDIR      = 4;

    typedef logic [NDIR-1:0] dir_t;

    // Priority list, highest first in the most significant field: up > down > left > right.
    localparam logic [7:0] DIR_PRIO = {2'd3, 2'd2, 2'd1, 2'd0};

    // An opposing pair pressed together means that axis is released.
    function automatic dir_t strip_opposed(input dir_t v);
        dir_t o;
        o = v;
        if (v[DIR_RIGHT] && v[DIR_LEFT]) begin
            o[DIR_RIGHT] = 1'b0;
            o[DIR_LEFT]  = 1'b0;
        end else begin
            o = o;
        end
        if (v[DIR_UP] && v[DIR_DOWN]) begin
            o[DIR_UP]   = 1'b0;
            o[DIR_DOWN] = 1'b0;
        end else begin
            o = o;
        end
        return o;
    endfunction

    // One-hot pick of the highest-priority pressed direction, zero if none.
    function automatic dir_t prio_pick(input dir_t v);
        dir_t       r;
        logic [1:0] idx;
        r = 4'b0000;
        for (int i = NDIR - 1; i >= 0; i--) begin
            idx = DIR_PRIO[2*i +: 2];
            if ((r == 4'b0000) && v[idx]) begin
                r[idx] = 1'b1;
            end else begin
                r = r;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/jtframe_4way_dbnc.sv
// Debounce stage: a raw direction pattern becomes the held pattern only after
// it has been sampled identically for DEBOUNCE consecutive clocks.
module jtframe_4way_dbnc
    import jtframe_joy_pkg::*;
#(
    parameter int DEBOUNCE = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] raw_i,
    output logic [3:0] held_o
);

    localparam logic [7:0] DB_LIM = 8'(DEBOUNCE);

    dir_t       cand_q, cand_d;
    dir_t       held_q, held_d;
    logic [7:0] cnt_q, cnt_d;

    // Count identical samples; any change restarts at one, the count saturates.
    always_comb begin
        cand_d = raw_i;
        if (raw_i != cand_q) begin
            cnt_d = 8'd1;
        end else if (cnt_q == 8'hFF) begin
            cnt_d = cnt_q;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
        if (cnt_d >= DB_LIM) begin
            held_d = raw_i;
        end else begin
            held_d = held_q;
        end
    end

    // Candidate, counter and held-pattern registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q <= 4'b0000;
            cnt_q  <= 8'd0;
            held_q <= 4'b0000;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            held_q <= held_d;
        end
    end

    assign held_o = held_q;

endmodule

// File: rtl/jtframe_4way_filter.sv
// 8-way to 4-way joystick filter with registered output. Define
// JTFRAME_4WAY_DEBOUNCE_EN to insert the jtframe_4way_dbnc input debouncer.
module jtframe_4way_filter
    import jtframe_joy_pkg::*;
#(
    parameter int DEBOUNCE = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [3:0] joy8way,
    output logic [3:0] joy4way
);

    if ((DEBOUNCE < 1) || (DEBOUNCE > 255)) begin : g_bad_debounce
        $error("jtframe_4way_filter: DEBOUNCE must be within 1..255");
    end

    dir_t in_s, valid_s, filt_s;
    dir_t joy_q, joy_d;
    dir_t last_q, last_d;

`ifdef JTFRAME_4WAY_DEBOUNCE_EN
    jtframe_4way_dbnc #(
        .DEBOUNCE (DEBOUNCE)
    ) u_dbnc (
        .clk    (clk),
        .rst    (rst),
        .raw_i  (joy8way),
        .held_o (in_s)
    );
`else
    assign in_s = joy8way;
`endif

    // last_q is always one-hot or zero, so overlap means the old direction is still pressed.
    always_comb begin
        valid_s = strip_opposed(in_s);
        if (valid_s == 4'b0000) begin
            filt_s = 4'b0000;
        end else if ((valid_s & last_q) != 4'b0000) begin
            filt_s = last_q;
        end else begin
            filt_s = prio_pick(valid_s);
        end
    end

    // The last direction follows the filter even in pass-through so enabling never glitches.
    always_comb begin
        last_d = filt_s;
        if (enable) begin
            joy_d = filt_s;
        end else begin
            joy_d = in_s;
        end
    end

    // Output and last-direction registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            joy_q  <= 4'b0000;
            last_q <= 4'b0000;
        end else begin
            joy_q  <= joy_d;
            last_q <= last_d;
        end
    end

    assign joy4way = joy_q;

endmodule

// File: tb/tb_jtframe_4way_filter.sv
// Self-checking bench for jtframe_4way_filter: directed vectors with literal
// expectations plus a per-cycle comparison against a behavioural model.
module tb_jtframe_4way_filter;

`ifdef JTFRAME_4WAY_DEBOUNCE_EN
    localparam int DB = 4;
`else
    localparam int DB = 0;
`endif
    localparam int LAT = DB + 1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       enable = 1'b0;
    logic [3:0] joy8way = 4'hF;
    logic [3:0] joy4way;

    int checks = 0;
    int failures = 0;
    bit model_on = 1'b0;

    jtframe_4way_filter #(
        .DEBOUNCE ((DB == 0) ? 15 : DB)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .enable  (enable),
        .joy8way (joy8way),
        .joy4way (joy4way)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [3:0] act, input logic [3:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
        end
    endtask

    // Reference rules written straight from the direction semantics.
    function automatic logic [3:0] ref_filter(input logic [3:0] raw, input logic [3:0] prev);
        logic [3:0] v;
        v = raw;
        if (v[0] && v[1]) v[1:0] = 2'b00;
        if (v[2] && v[3]) v[3:2] = 2'b00;
        if (v == 4'b0000) return 4'b0000;
        if ($countones(v) == 1) return v;
        if ((v & prev) != 4'b0000) return prev;
        if (v[3]) return 4'b1000;
        if (v[2]) return 4'b0100;
        if (v[1]) return 4'b0010;
        return 4'b0001;
    endfunction

    logic [3:0] m_exp = 4'b0000;
    logic [3:0] m_last = 4'b0000;
    logic [3:0] m_acc = 4'b0000;
    logic [3:0] m_in = 4'b0000;
    bit         m_en = 1'b0;
    logic [3:0] m_hist[$];

    // Behavioural model: accepted pattern, filtered value and expected output.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_exp  = 4'b0000;
            m_last = 4'b0000;
            m_acc  = 4'b0000;
            m_in   = 4'b0000;
            m_en   = 1'b0;
            m_hist.delete();
        end else begin
            logic [3:0] f;
            bit         same;
            m_in   = (DB == 0) ? joy8way : m_acc;
            f      = ref_filter(m_in, m_last);
            m_exp  = enable ? f : m_in;
            m_en   = enable;
            m_last = f;
            if (DB > 0) begin
                m_hist.push_back(joy8way);
                if (m_hist.size() > DB) void'(m_hist.pop_front());
                same = (m_hist.size() == DB);
                foreach (m_hist[k]) if (m_hist[k] != joy8way) same = 1'b0;
                if (same) m_acc = joy8way;
            end
        end
    end

    // Per-cycle compare against the model plus 4-way invariants.
    always @(negedge clk) begin
        if (model_on) begin
            chk("model", joy4way, m_exp);
            if (rst && m_en) begin
                checks++;
                if (($countones(joy4way) > 1) || ((joy4way & ~m_in) != 4'b0000)) begin
                    failures++;
                    $display("FAIL invariant: got %b with input %b at %0t", joy4way, m_in, $time);
                end
            end
        end
    end

    task automatic drive(input bit en, input logic [3:0] v);
        @(negedge clk);
        #1;
        enable  = en;
        joy8way = v;
    endtask

    task automatic apply(input string name, input bit en, input logic [3:0] v, input logic [3:0] req);
        drive(en, v);
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        chk(name, joy4way, req);
    endtask

    initial begin
        // Reset held with all directions pressed.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_out", joy4way, 4'b0000);
        @(negedge clk);
        #1;
        rst = 1'b1;
        model_on = 1'b1;
        repeat (LAT) @(posedge clk);
        @(negedge clk);
        chk("reset_release_pass", joy4way, 4'hF);

        apply("pass_1001", 1'b0, 4'b1001, 4'b1001);
        apply("pass_0000", 1'b0, 4'b0000, 4'b0000);

        apply("single_up", 1'b1, 4'b1000, 4'b1000);
        apply("diag_hold_up", 1'b1, 4'b1001, 4'b1000);
        apply("single_right", 1'b1, 4'b0001, 4'b0001);

        apply("release", 1'b1, 4'b0000, 4'b0000);
        apply("fresh_down_left", 1'b1, 4'b0110, 4'b0100);
        apply("all_opposed", 1'b1, 4'b1111, 4'b0000);
        apply("lr_opposed_up", 1'b1, 4'b1011, 4'b1000);
        apply("ud_opposed_left", 1'b1, 4'b1110, 4'b0010);
        apply("fresh_left_right_up", 1'b1, 4'b0000, 4'b0000);
        apply("fresh_left_right", 1'b1, 4'b0011, 4'b0000);
        apply("fresh_up_right", 1'b1, 4'b1001, 4'b1000);

        // Enable toggled mid-press, then back: no glitch, diagonal held.
        apply("toggle_off", 1'b0, 4'b1001, 4'b1001);
        apply("toggle_on", 1'b1, 4'b1001, 4'b1000);

`ifdef JTFRAME_4WAY_DEBOUNCE_EN
        apply("dbnc_idle", 1'b1, 4'b0000, 4'b0000);
        drive(1'b1, 4'b0001);
        repeat (2) drive(1'b1, 4'b0001);
        drive(1'b1, 4'b0000);
        repeat (8) @(negedge clk);
        chk("dbnc_pulse3", joy4way, 4'b0000);
        drive(1'b1, 4'b0001);
        repeat (3) drive(1'b1, 4'b0001);
        drive(1'b1, 4'b0000);
        @(negedge clk);
        chk("dbnc_stable4", joy4way, 4'b0001);
        repeat (8) @(negedge clk);
`endif

        // Asynchronous reset mid-press.
        apply("pre_reset_up", 1'b1, 4'b1000, 4'b1000);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk("async_reset", joy4way, 4'b0000);
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk("reset_hold_until_clk", joy4way, 4'b0000);

        // Random stress with filtering on.
        for (int i = 0; i < 10000; i++) begin
            if ((DB == 0) || ($urandom_range(0, 5) == 0)) begin
                drive(1'b1, 4'($urandom_range(0, 15)));
            end else begin
                drive(1'b1, joy8way);
            end
        end
        // Random stress with enable toggling.
        for (int i = 0; i < 1000; i++) begin
            drive(($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)));
        end

        repeat (LAT + 1) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jtframe_4way_filter.md
Name: jtframe_4way_filter

Overview:
- Converts an active-high 8-way joystick direction nibble into a 4-way nibble: at most one direction is asserted at any time.
- Sits between board joystick synchronisers and game input mapping, one instance per player.
- Filtering applies only when `enable` is high (core-selected 4-way games). Otherwise the input passes through registered.

Parameters:
- DEBOUNCE, 15: number of consecutive stable clk cycles required before a new input pattern is accepted. Only used when JTFRAME_4WAY_DEBOUNCE_EN is defined. Range 1..255.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset asserted).
- enable  input  1  1 = 4-way filtering, 0 = pass-through. Sampled synchronously.
- joy8way  input  4  raw directions, active high. Bit 0 right, 1 left, 2 down, 3 up.
- joy4way  output  4  filtered directions, active high, same bit order; registered.

Behaviour:
- Reset (rst=0, asynchronous): joy4way=4'b0000; internal last-direction register cleared; debounce counter cleared.
- Latency: joy4way is updated one clk after the (accepted) input, in both modes.
- enable=0: joy4way <= joy8way, unmodified. Opposing and diagonal bits are passed as-is. The last-direction register still tracks the filtered result so that enabling the filter causes no glitch.
- enable=1, filter computed on the accepted input vector `in`:
  - in==0: output 0.
  - Exactly one bit set: output = in.
  - Opposing pair set (right+left, or up+down), alone or with other bits: that axis is treated as released. Filtering continues on the remaining bits; if none remain, output 0.
  - Two or more valid bits (diagonal): if the previous output bit is still among them, hold the previous output. Otherwise select by fixed priority up > down > left > right.
- Output is always one-hot or zero when enable=1. This is a verification invariant.
- Toggling enable mid-press takes effect on the next clk; there is no extra state flush.
- Reset asserted mid-operation clears everything immediately; output stays 0 until the first clk after release.

Optional Feature:
- JTFRAME_4WAY_DEBOUNCE_EN defined:
  - `in` is a debounced copy of joy8way. A new joy8way pattern replaces `in` only after being identical for DEBOUNCE consecutive clocks.
  - Any change restarts the counter. The counter saturates.
  - Total latency from a stable change is DEBOUNCE+1 clocks. This also applies when enable=0.
- Not defined: `in` = joy8way directly and the DEBOUNCE parameter is ignored.

Decomposition:
- Shared package jtframe_joy_pkg:
  - direction bit indices DIR_RIGHT=0, DIR_LEFT=1, DIR_DOWN=2, DIR_UP=3.
  - localparam for the up>down>left>right priority order.
- One natural sub-module: jtframe_4way_dbnc (the debounce counter plus held vector), instantiated only under JTFRAME_4WAY_DEBOUNCE_EN.

Test Plan:
- Reset: hold rst=0 with joy8way=4'hF -> joy4way=0; release, enable=0 -> next clk joy4way=4'hF.
- Pass-through: enable=0, joy8way=4'b1001 -> joy4way=4'b1001 one clk later.
- Single then diagonal hold: enable=1, joy8way=4'b1000 -> 4'b1000; then 4'b1001 -> stays 4'b1000; then 4'b0001 -> 4'b0001.
- Fresh diagonal priority: enable=1, from 0 apply 4'b0110 (down+left) -> 4'b0100. Apply 4'b1111 -> 0. Apply 4'b1011 -> 4'b1000.
- Random stress, enable=1, 10k cycles random joy8way -> joy4way always one-hot or zero, never an unpressed bit.
- With JTFRAME_4WAY_DEBOUNCE_EN, DEBOUNCE=4:
  - a 3-cycle pulse on 4'b0001 -> output stays 0.
  - a 4-cycle stable 4'b0001 -> output 4'b0001 five clocks after the change.
